inst_fetch_queue: RTL and testbench

Instruction fetch stage directly upstream of the single-cycle decode/execute datapath. It owns the fetch PC, issues word reads to instruction memory over a REQ/ACK handshake that tolerates variable latency, and buffers the returned words in a small FIFO. The FIFO presents {IR, IR_PC} to decode over a VALID/READY handshake. A redirect input flushes the queue and restarts fetch at a new PC, in preparation for branches and jumps.

---
 rtl/inst_fetch_queue.sv | 108 ++++++++++
 tb/tb_inst_fetch_queue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, reads instruction memory over a
// REQ/ACK handshake and buffers returned words in a FIFO presented to decode.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_DATA,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IR_VALID,
  output logic [31:0] IR,
  output logic [31:0] IR_PC,
  input  logic        IR_READY
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc, fetch_pc_nxt;
  logic [31:0]   req_addr;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_after;
  logic [31:0]   ir_mem [DEPTH];
  logic [31:0]   pc_mem [DEPTH];
  logic          beat, push, pop;

  assign beat        = (state != S_IDLE) && IMEM_ACK;
  assign push        = (state == S_WAIT) && beat && !REDIRECT;
  assign pop         = IR_VALID && IR_READY && !REDIRECT;
  assign count_after = count + CW'(push) - CW'(pop);

  assign IMEM_REQ  = (state != S_IDLE) && !RST;
  assign IMEM_ADDR = req_addr;
  assign IR_VALID  = (count != '0) && !RST;
  assign IR        = ir_mem[rd_ptr];
  assign IR_PC     = pc_mem[rd_ptr];

  always_comb begin
    fetch_pc_nxt = fetch_pc;
    if (REDIRECT)
      fetch_pc_nxt = REDIRECT_PC & ~32'h3;
    else if (push)
      fetch_pc_nxt = fetch_pc + 32'd4;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (count < FULL && !REDIRECT) state_nxt = S_WAIT;
      S_WAIT: begin
        // A beat colliding with a redirect is simply dropped; no DROP needed.
        if (beat)
          state_nxt = (!REDIRECT && count_after < FULL) ? S_WAIT : S_IDLE;
        else if (REDIRECT)
          state_nxt = S_DROP;
      end
      S_DROP: if (beat) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      // DROP keeps the stale address on the bus until the old beat lands.
      if (state_nxt == S_WAIT)
        req_addr <= fetch_pc_nxt;
      if (REDIRECT) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count_after;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      ir_mem[wr_ptr] <= IMEM_DATA;
      pc_mem[wr_ptr] <= req_addr;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: queue-based reference model checked every cycle,
// directed scenarios pinned with literal expectations, then random traffic.
module tb_inst_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IMEM_REQ, IMEM_ACK;
  logic [31:0] IMEM_ADDR, IMEM_DATA;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = 32'h0;
  logic        IR_VALID;
  logic [31:0] IR, IR_PC;
  logic        IR_READY = 1'b0;
  logic        ack_gate = 1'b0;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00000020;
      32'h4:   return 32'h20080003;
      32'h8:   return 32'h20090005;
      32'hC:   return 32'h01095020;
      default: return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endcase
  endfunction

  assign IMEM_ACK  = IMEM_REQ & ack_gate;
  assign IMEM_DATA = mem_word(IMEM_ADDR);

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .RST(RST),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
    .IR_VALID(IR_VALID), .IR(IR), .IR_PC(IR_PC), .IR_READY(IR_READY)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: queue of fetched entries plus one outstanding request,
  // which may be marked stale after a redirect.
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc   = 32'h0;
  logic [31:0] m_addr = 32'h0;
  bit          m_out, m_stale, m_live;

  int ack_mode = 0;   // 0: fixed latency, 1: random, 2: manual ack_gate
  int lat      = 0;
  int wait_cnt = 0;

  logic [31:0] beat_log[$];
  ent_t        pop_log[$];

  task automatic cycle();
    bit          p_rst, p_redir, p_ready, p_beat, d_beat, d_req;
    logic [31:0] p_rpc, p_data;
    int          pre_size;
    if (ack_mode == 0)      ack_gate = (wait_cnt >= lat);
    else if (ack_mode == 1) ack_gate = 1'($urandom_range(0, 1));
    #1;
    if (m_live) begin
      chk("imem_req", IMEM_REQ, m_out && !RST);
      if (m_out && !RST) chk("imem_addr", IMEM_ADDR, m_addr);
      chk("ir_valid", IR_VALID, (q.size() != 0) && !RST);
      if (q.size() != 0 && !RST) begin
        chk("ir", IR, q[0].ir);
        chk("ir_pc", IR_PC, q[0].pc);
      end
    end
    p_rst = RST; p_redir = REDIRECT; p_ready = IR_READY; p_rpc = REDIRECT_PC;
    p_beat = m_out && ack_gate;
    p_data = mem_word(m_addr);
    d_req  = IMEM_REQ;
    d_beat = IMEM_REQ && IMEM_ACK;
    if (!RST) begin
      if (d_beat) beat_log.push_back(IMEM_ADDR);
      if (IR_VALID && IR_READY && !REDIRECT) pop_log.push_back(ent_t'{ir: IR, pc: IR_PC});
    end
    @(posedge CLK);
    if (p_rst) begin
      q.delete();
      m_pc = RESET_PC; m_out = 0; m_stale = 0; m_live = 1;
    end else if (m_live) begin
      pre_size = q.size();
      if (p_redir) begin
        q.delete();
        m_pc = {p_rpc[31:2], 2'b00};
        if (m_out && !p_beat) m_stale = 1;
        else begin m_out = 0; m_stale = 0; end
      end else begin
        if (p_ready && pre_size != 0) void'(q.pop_front());
        if (m_out && p_beat) begin
          m_out = 0;
          if (!m_stale) begin
            chk("push_room", q.size() < DEPTH, 1);
            q.push_back(ent_t'{ir: p_data, pc: m_addr});
            m_pc = m_pc + 32'd4;
            if (q.size() < DEPTH) begin m_out = 1; m_addr = m_pc; end
          end
          m_stale = 0;
        end else if (!m_out && pre_size < DEPTH) begin
          m_out = 1; m_addr = m_pc;
        end
      end
    end
    if (p_rst || d_beat) wait_cnt = 0;
    else if (d_req)      wait_cnt++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    RST = 1'b1; REDIRECT = 1'b0;
    cycle(); cycle();
    RST = 1'b0;
  endtask

  task automatic clear_logs();
    beat_log.delete();
    pop_log.delete();
  endtask

  logic [31:0] exp_ir [4] = '{32'h00000020, 32'h20080003, 32'h20090005, 32'h01095020};

  initial begin
    // Reset + streaming with zero-wait ACK
    ack_mode = 0; lat = 0; IR_READY = 1'b1;
    do_reset();
    clear_logs();
    chk("c0_valid", IR_VALID, 0);
    chk("c0_req", IMEM_REQ, 0);
    cycle();
    chk("c1_valid", IR_VALID, 0);
    chk("c1_req", IMEM_REQ, 1);
    cycle();
    chk("c2_valid", IR_VALID, 1);
    run(6);
    chk("stream_beats", beat_log.size() >= 4, 1);
    chk("stream_pops", pop_log.size() >= 4, 1);
    for (int i = 0; i < 4; i++) begin
      if (i < beat_log.size()) chk("stream_addr", beat_log[i], 32'(i * 4));
      if (i < pop_log.size()) begin
        chk("stream_ir_pc", pop_log[i].pc, 32'(i * 4));
        chk("stream_ir", pop_log[i].ir, exp_ir[i]);
      end
    end

    // Backpressure
    IR_READY = 1'b0;
    do_reset();
    clear_logs();
    run(10);
    chk("bp_beats", beat_log.size(), 4);
    chk("bp_req", IMEM_REQ, 0);
    chk("bp_valid", IR_VALID, 1);
    chk("bp_head_pc", IR_PC, 32'h0);
    IR_READY = 1'b1;
    clear_logs();
    cycle();
    IR_READY = 1'b0;
    run(5);
    chk("bp_one_pop", pop_log.size(), 1);
    chk("bp_one_beat", beat_log.size(), 1);
    if (beat_log.size() > 0) chk("bp_refill_addr", beat_log[0], 32'h10);

    // Variable latency
    lat = 3; IR_READY = 1'b1;
    do_reset();
    clear_logs();
    run(20);
    chk("lat_pops", pop_log.size() >= 3, 1);
    for (int i = 0; i < 3 && i < pop_log.size(); i++) chk("lat_ir_pc", pop_log[i].pc, 32'(i * 4));

    // Redirect while a request is pending
    IR_READY = 1'b0; ack_mode = 2; ack_gate = 1'b1;
    do_reset();
    run(3);
    ack_gate = 1'b0;
    cycle();
    chk("rd_pend_req", IMEM_REQ, 1);
    chk("rd_pend_addr", IMEM_ADDR, 32'h8);
    REDIRECT = 1'b1; REDIRECT_PC = 32'h103;
    cycle();
    REDIRECT = 1'b0;
    chk("rd_flush_valid", IR_VALID, 0);
    chk("rd_drop_req", IMEM_REQ, 1);
    chk("rd_drop_addr", IMEM_ADDR, 32'h8);
    run(3);
    chk("rd_drop_hold", IMEM_ADDR, 32'h8);
    ack_gate = 1'b1;
    cycle();
    IR_READY = 1'b1;
    clear_logs();
    for (int i = 0; i < 20 && pop_log.size() == 0; i++) cycle();
    chk("rd_timeout", pop_log.size() != 0, 1);
    if (beat_log.size() > 0) chk("rd_new_addr", beat_log[0], 32'h100);
    if (pop_log.size() > 0) chk("rd_first_pc", pop_log[0].pc, 32'h100);

    // Redirect, pop and beat in the same cycle
    ack_mode = 0; lat = 0; IR_READY = 1'b1;
    do_reset();
    run(5);
    chk("rpb_pre_valid", IR_VALID, 1);
    chk("rpb_pre_req", IMEM_REQ, 1);
    REDIRECT = 1'b1; REDIRECT_PC = 32'h200;
    cycle();
    REDIRECT = 1'b0;
    chk("rpb_valid", IR_VALID, 0);
    clear_logs();
    run(6);
    if (pop_log.size() > 0) chk("rpb_first_pc", pop_log[0].pc, 32'h200);
    else chk("rpb_pops", 0, 1);

    // PC wrap, then reset in the middle of a transaction
    REDIRECT = 1'b1; REDIRECT_PC = 32'hFFFFFFFE;
    cycle();
    REDIRECT = 1'b0;
    clear_logs();
    run(6);
    chk("wrap_beats", beat_log.size() >= 2, 1);
    if (beat_log.size() >= 2) begin
      chk("wrap_addr0", beat_log[0], 32'hFFFFFFFC);
      chk("wrap_addr1", beat_log[1], 32'h0);
    end
    ack_mode = 2; ack_gate = 1'b0;
    run(2);
    chk("rst_pre_req", IMEM_REQ, 1);
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    chk("rst_req", IMEM_REQ, 0);
    chk("rst_valid", IR_VALID, 0);
    ack_mode = 0; lat = 0;
    clear_logs();
    run(4);
    if (beat_log.size() > 0) chk("rst_restart_addr", beat_log[0], RESET_PC);
    else chk("rst_restart_beats", 0, 1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) begin
        ack_mode = int'($urandom_range(0, 1));
        lat = int'($urandom_range(0, 3));
      end
      IR_READY = ($urandom_range(0, 3) != 0);
      REDIRECT = ($urandom_range(0, 19) == 0);
      REDIRECT_PC = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFE0 | 32'($urandom_range(0, 31)))
                                                 : $urandom;
      RST = ($urandom_range(0, 399) == 0);
      cycle();
    end
    RST = 1'b0; REDIRECT = 1'b0;
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
